tl_tx_fc_gate: RTL and testbench

TL_TX_FC_GATE -- requirements
Module: tl_tx_fc_gate

---
 rtl/tl_pkg.sv | 6 +
 rtl/tl_fc_class_ctr.sv | 66 ++++++
 rtl/tl_tx_fc_gate.sv | 56 +++++
 tb/tb_tl_tx_fc_gate.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared transaction-layer flow-control types and default counter widths
package tl_pkg;
  typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} tl_fc_class_e;
  localparam int FC_HDR_W_DEF = 8;
  localparam int FC_DATA_W_DEF = 12;
endpackage

// File: rtl/tl_fc_class_ctr.sv
// tl_fc_class_ctr: one credit class's limits, consumed counters and credit check (TL_FC_INFINITE_EN adds infinite flags)
module tl_fc_class_ctr
  import tl_pkg::*;
#(
  parameter int HDR_W = FC_HDR_W_DEF,
  parameter int DATA_W = FC_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic [HDR_W-1:0]  upd_hdr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              take,
  input  logic [DATA_W-1:0] need_data,
  output logic              ok
);
  logic [HDR_W-1:0] lim_hdr, cons_hdr, left_hdr;
  logic [DATA_W-1:0] lim_data, cons_data, left_data;
  logic inf_hdr, inf_data;
  // modular distance test: a result in the upper half means the need overshoots the limit
  assign left_hdr = lim_hdr - cons_hdr - HDR_W'(1);
  assign left_data = lim_data - cons_data - need_data;
  assign ok = (inf_hdr || left_hdr <= (HDR_W'(1) << (HDR_W - 1))) &&
              (inf_data || left_data <= (DATA_W'(1) << (DATA_W - 1)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_hdr <= '0;
      lim_data <= '0;
      cons_hdr <= '0;
      cons_data <= '0;
    end else if (clr) begin
      lim_hdr <= '0;
      lim_data <= '0;
      cons_hdr <= '0;
      cons_data <= '0;
    end else begin
      if (take) cons_hdr <= cons_hdr + HDR_W'(1);
      if (take) cons_data <= cons_data + need_data;
      if (upd && !inf_hdr) lim_hdr <= upd_hdr;
      if (upd && !inf_data) lim_data <= upd_data;
    end
  end
`ifdef TL_FC_INFINITE_EN
  logic seen;
  // only the first advertisement since link-up decides whether a field is infinite
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen <= 1'b0;
      inf_hdr <= 1'b0;
      inf_data <= 1'b0;
    end else if (clr) begin
      seen <= 1'b0;
      inf_hdr <= 1'b0;
      inf_data <= 1'b0;
    end else if (upd && !seen) begin
      seen <= 1'b1;
      inf_hdr <= upd_hdr == '0;
      inf_data <= upd_data == '0;
    end
  end
`else
  assign inf_hdr = 1'b0;
  assign inf_data = 1'b0;
`endif
endmodule

// File: rtl/tl_tx_fc_gate.sv
// tl_tx_fc_gate: TLP transmit gate checking P/NP/CPL flow-control credits (optional TL_FC_INFINITE_EN)
module tl_tx_fc_gate
  import tl_pkg::*;
#(
  parameter int HDR_W = FC_HDR_W_DEF,
  parameter int DATA_W = FC_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_init_done,
  input  logic              fc_upd_valid,
  input  logic [1:0]        fc_upd_type,
  input  logic [HDR_W-1:0]  fc_upd_hdr,
  input  logic [DATA_W-1:0] fc_upd_data,
  input  logic              req_valid,
  input  logic [1:0]        req_type,
  input  logic              req_has_data,
  input  logic [9:0]        req_len,
  output logic              req_ready,
  output logic [2:0]        cls_blocked
);
  logic init_q, link_fall;
  logic [10:0] need_dw, need_cr;
  logic [DATA_W-1:0] need_data;
  logic [3:0] ok;
  assign link_fall = init_q && !fc_init_done;
  // a zero length field encodes 1024 DW, i.e. 256 data credits
  assign need_dw = (req_len == '0) ? 11'd1024 : {1'b0, req_len};
  assign need_cr = (need_dw + 11'd3) >> 2;
  assign need_data = req_has_data ? DATA_W'(need_cr) : '0;
  assign ok[3] = 1'b0;
  assign req_ready = fc_init_done && ok[req_type];
  for (genvar c = 0; c < 3; c++) begin : g_cls
    tl_fc_class_ctr #(.HDR_W(HDR_W), .DATA_W(DATA_W)) u_ctr (
      .clk(clk),
      .rst(rst),
      .clr(link_fall),
      .upd(fc_upd_valid && fc_upd_type == 2'(c)),
      .upd_hdr(fc_upd_hdr),
      .upd_data(fc_upd_data),
      .take(req_valid && req_ready && req_type == 2'(c)),
      .need_data(need_data),
      .ok(ok[c])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      cls_blocked <= '0;
    end else begin
      init_q <= fc_init_done;
      if (link_fall) cls_blocked <= '0;
      else if (req_valid && req_type != 2'd3) cls_blocked[req_type] <= !req_ready;
    end
  end
endmodule

// File: tb/tb_tl_tx_fc_gate.sv
// tb_tl_tx_fc_gate: scoreboard bench comparing tl_tx_fc_gate against a credit model
module tb_tl_tx_fc_gate;
  import tl_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic fc_init_done = 1'b0, fc_upd_valid = 1'b0, req_valid = 1'b0, req_has_data = 1'b0;
  logic [1:0] fc_upd_type = 2'd0, req_type = 2'd0;
  logic [7:0] fc_upd_hdr = '0;
  logic [11:0] fc_upd_data = '0;
  logic [9:0] req_len = '0;
  logic req_ready;
  logic [2:0] cls_blocked;
  always #5 clk = ~clk;
  tl_tx_fc_gate dut (
    .clk(clk), .rst(rst), .fc_init_done(fc_init_done), .fc_upd_valid(fc_upd_valid),
    .fc_upd_type(fc_upd_type), .fc_upd_hdr(fc_upd_hdr), .fc_upd_data(fc_upd_data),
    .req_valid(req_valid), .req_type(req_type), .req_has_data(req_has_data),
    .req_len(req_len), .req_ready(req_ready), .cls_blocked(cls_blocked)
  );
  typedef struct {string tag; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int lim_h[3], cons_h[3], lim_d[3], cons_d[3];
  bit inf_h[3], inf_d[3], seen[3];
  bit [2:0] blk;
  bit init_q;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic pop_check(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask
  function automatic int need_d(bit h, int l);
    return !h ? 0 : (l == 0 ? 256 : (l + 3) / 4);
  endfunction
  function automatic bit model_ok(int c, bit h, int l);
    if (c > 2) return 1'b0;
    return (inf_h[c] || ((lim_h[c] - cons_h[c] - 1) & 255) <= 128) &&
           (inf_d[c] || ((lim_d[c] - cons_d[c] - need_d(h, l)) & 4095) <= 2048);
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      lim_h[i] = 0; cons_h[i] = 0; lim_d[i] = 0; cons_d[i] = 0;
      inf_h[i] = 0; inf_d[i] = 0; seen[i] = 0;
    end
    blk = '0;
  endtask
  task automatic step(bit uv, int ut, int uh, int ud, bit rv, int rt, bit rh, int rl, bit init);
    bit er;
    fc_init_done = init; fc_upd_valid = uv; fc_upd_type = 2'(ut);
    fc_upd_hdr = 8'(uh); fc_upd_data = 12'(ud);
    req_valid = rv; req_type = 2'(rt); req_has_data = rh; req_len = 10'(rl);
    er = init && model_ok(rt, rh, rl);
    sb.push_back('{tag: "req_ready", exp: 32'(er)});
    @(negedge clk);
    pop_check(32'(req_ready));
    if (init_q && !init) model_clear();
    else begin
      if (rv && rt < 3) blk[rt] = !er;
      if (rv && er) begin
        cons_h[rt] = (cons_h[rt] + 1) & 255;
        cons_d[rt] = (cons_d[rt] + need_d(rh, rl)) & 4095;
      end
      if (uv && ut < 3) begin
        if (!inf_h[ut]) lim_h[ut] = uh;
        if (!inf_d[ut]) lim_d[ut] = ud;
`ifdef TL_FC_INFINITE_EN
        if (!seen[ut]) begin
          seen[ut] = 1; inf_h[ut] = uh == 0; inf_d[ut] = ud == 0;
        end
`endif
      end
    end
    init_q = init;
    sb.push_back('{tag: "cls_blocked", exp: 32'(blk)});
    @(posedge clk);
    #1;
    pop_check(32'(cls_blocked));
    fc_upd_valid = 1'b0; req_valid = 1'b0;
  endtask
  initial begin
    model_clear();
    init_q = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back('{tag: "reset_ready", exp: 32'd0});
    pop_check(32'(req_ready));
    sb.push_back('{tag: "reset_blocked", exp: 32'd0});
    pop_check(32'(cls_blocked));
    @(posedge clk);
    #1 rst = 1'b0;
    // link down: P request is refused and flagged
    step(0, 0, 0, 0, 1, FC_P, 1, 4, 0);
    // P limits hdr=2 data=8, then bring the link up
    step(1, FC_P, 2, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, FC_P, 1, 16, 1);
    // drive NP consumed header count to 0xFE while raising the limit alongside
    step(1, FC_NP, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 254; i++) step(1, FC_NP, i + 2, 0, 1, FC_NP, 0, 1, 1);
    step(1, FC_NP, 0, 'h100, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, FC_NP, 0, 1, 1);
    // len=0 needs 256 data credits; 255 available, then same-cycle update to 256
    step(1, FC_P, 3, 263, 1, FC_P, 1, 0, 1);
    step(1, FC_P, 3, 264, 1, FC_P, 1, 0, 1);
    step(0, 0, 0, 0, 1, FC_P, 1, 0, 1);
    step(0, 0, 0, 0, 1, FC_P, 1, 0, 1);
    // CPL advertised as zero: infinite when enabled, otherwise a hard zero limit
    step(1, FC_CPL, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, FC_CPL, 1, 0, 1);
    // link drop clears everything; class 3 is never ready and its updates ignored
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 50, 50, 1, 3, 0, 1, 1);
    step(0, 0, 0, 0, 1, FC_P, 0, 1, 1);
    step(1, FC_P, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, FC_P, 0, 1, 1);
    step(0, 0, 0, 0, 1, FC_NP, 0, 1, 1);
    // asynchronous reset mid-cycle clears flags without waiting for an edge
    #2 rst = 1'b1;
    #1;
    model_clear();
    init_q = 0;
    sb.push_back('{tag: "async_rst_blocked", exp: 32'd0});
    pop_check(32'(cls_blocked));
    sb.push_back('{tag: "async_rst_ready", exp: 32'd0});
    pop_check(32'(req_ready));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
